// File: rtl/traffic_light_sequencer_if.sv
// Pedestrian/hold controls in, FSM state and the twelve lamp colours out.
// The master modport drives the inputs and the slave modport is the sequencer side.
interface traffic_light_sequencer_if;
  logic        ped_button;
  logic        hold;
  logic [3:0]  state_out;
  logic        ped_pending;
  logic [11:0] reg_0_colour;
  logic [11:0] reg_1_colour;
  logic [11:0] reg_2_colour;
  logic [11:0] reg_3_colour;
  logic [11:0] reg_4_colour;
  logic [11:0] reg_5_colour;
  logic [11:0] reg_6_colour;
  logic [11:0] reg_7_colour;
  logic [11:0] reg_8_colour;
  logic [11:0] reg_9_colour;
  logic [11:0] reg_10_colour;
  logic [11:0] reg_11_colour;

  modport master (
    output ped_button, hold,
    input  state_out, ped_pending,
    input  reg_0_colour, reg_1_colour, reg_2_colour, reg_3_colour,
    input  reg_4_colour, reg_5_colour, reg_6_colour, reg_7_colour,
    input  reg_8_colour, reg_9_colour, reg_10_colour, reg_11_colour
  );

  modport slave (
    input  ped_button, hold,
    output state_out, ped_pending,
    output reg_0_colour, reg_1_colour, reg_2_colour, reg_3_colour,
    output reg_4_colour, reg_5_colour, reg_6_colour, reg_7_colour,
    output reg_8_colour, reg_9_colour, reg_10_colour, reg_11_colour
  );
endinterface

// File: rtl/traffic_light_sequencer.sv
// Timed two-road junction sequencer with a latched pedestrian walk phase.
// The lamp colours are registered one cycle behind the state and timer.
module traffic_light_sequencer #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned T_STRAIGHT = 10,
  parameter int unsigned T_RIGHT    = 5,
  parameter int unsigned T_YELLOW   = 3,
  parameter int unsigned T_ALLRED   = 1,
  parameter int unsigned T_PED      = 8,
  parameter int unsigned T_FLASH    = 3,
  parameter logic [11:0] LAMP_OFF   = 12'h333
) (
  input logic clk,
  input logic reset,
  traffic_light_sequencer_if.slave bus
);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [11:0] RED = 12'hF00;
  localparam logic [11:0] YEL = 12'hFF0;
  localparam logic [11:0] GRN = 12'h0F0;

  typedef enum logic [3:0] {
    R1_STRAIGHT = 4'd0, R1_RIGHT = 4'd1, R1_YELLOW = 4'd2, ALLRED_A = 4'd3,
    R2_STRAIGHT = 4'd4, R2_RIGHT = 4'd5, R2_YELLOW = 4'd6, ALLRED_B = 4'd7,
    PED_WALK    = 4'd8
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        timer, timer_nx;
  logic [PW-1:0]     presc;
  logic              tick;
  logic              sync1, sync2, sync3, ped_edge;
  logic              ped_pending, walk_entry;
  logic [11:0][11:0] colour, colour_nx;

  function automatic logic [7:0] dur(state_t s);
    case (s)
      R1_STRAIGHT, R2_STRAIGHT: dur = 8'(T_STRAIGHT);
      R1_RIGHT, R2_RIGHT:       dur = 8'(T_RIGHT);
      R1_YELLOW, R2_YELLOW:     dur = 8'(T_YELLOW);
      PED_WALK:                 dur = 8'(T_PED);
      default:                  dur = 8'(T_ALLRED);
    endcase
  endfunction

  // hold stalls the prescaler so the partly elapsed tick resumes where it left off
  always_ff @(posedge clk or negedge reset)
    if (!reset)           presc <= '0;
    else if (!bus.hold)   presc <= (presc == PRE_MAX) ? '0 : presc + 1'b1;

  assign tick = !bus.hold && (presc == PRE_MAX);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.ped_button;
      sync2 <= sync1;
      sync3 <= sync2;
    end

  assign ped_edge = sync2 & ~sync3;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= R1_STRAIGHT;
      timer <= 8'(T_STRAIGHT);
    end else begin
      state <= state_nx;
      timer <= timer_nx;
    end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    if (tick) begin
      if (timer == 8'd1) begin
        case (state)
          R1_STRAIGHT: state_nx = R1_RIGHT;
          R1_RIGHT:    state_nx = R1_YELLOW;
          R1_YELLOW:   state_nx = ALLRED_A;
          ALLRED_A:    state_nx = R2_STRAIGHT;
          R2_STRAIGHT: state_nx = R2_RIGHT;
          R2_RIGHT:    state_nx = R2_YELLOW;
          R2_YELLOW:   state_nx = ALLRED_B;
          ALLRED_B:    state_nx = ped_pending ? PED_WALK : R1_STRAIGHT;
          default:     state_nx = R1_STRAIGHT;
        endcase
        timer_nx = dur(state_nx);
      end else begin
        timer_nx = timer - 8'd1;
      end
    end
  end

  // A request arriving on the entry edge or during the walk is served by this walk
  assign walk_entry = (state != PED_WALK) && (state_nx == PED_WALK);

  always_ff @(posedge clk or negedge reset)
    if (!reset)                                 ped_pending <= 1'b0;
    else if (walk_entry)                        ped_pending <= 1'b0;
    else if (ped_edge && state != PED_WALK)     ped_pending <= 1'b1;

  always_comb begin
    colour_nx = {12{LAMP_OFF}};
    case (state)
      R1_STRAIGHT: begin colour_nx[2] = GRN; colour_nx[6] = RED; colour_nx[4] = RED; end
      R1_RIGHT:    begin colour_nx[3] = GRN; colour_nx[6] = RED; colour_nx[4] = RED; end
      R1_YELLOW:   begin colour_nx[1] = YEL; colour_nx[6] = RED; colour_nx[4] = RED; end
      ALLRED_A:    begin colour_nx[0] = RED; colour_nx[6] = RED; colour_nx[4] = RED; end
      R2_STRAIGHT: begin colour_nx[8] = GRN; colour_nx[0] = RED; colour_nx[4] = RED; end
      R2_RIGHT:    begin colour_nx[5] = GRN; colour_nx[0] = RED; colour_nx[4] = RED; end
      R2_YELLOW:   begin colour_nx[7] = YEL; colour_nx[0] = RED; colour_nx[4] = RED; end
      ALLRED_B:    begin colour_nx[0] = RED; colour_nx[6] = RED; colour_nx[4] = RED; end
      PED_WALK: begin
        colour_nx[0] = RED;
        colour_nx[6] = RED;
        if (timer > 8'(T_FLASH) || timer[0]) colour_nx[9] = GRN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      colour    <= {12{LAMP_OFF}};
      colour[2] <= GRN;
      colour[4] <= RED;
      colour[6] <= RED;
    end else begin
      colour <= colour_nx;
    end

  assign bus.state_out     = state;
  assign bus.ped_pending   = ped_pending;
  assign bus.reg_0_colour  = colour[0];
  assign bus.reg_1_colour  = colour[1];
  assign bus.reg_2_colour  = colour[2];
  assign bus.reg_3_colour  = colour[3];
  assign bus.reg_4_colour  = colour[4];
  assign bus.reg_5_colour  = colour[5];
  assign bus.reg_6_colour  = colour[6];
  assign bus.reg_7_colour  = colour[7];
  assign bus.reg_8_colour  = colour[8];
  assign bus.reg_9_colour  = colour[9];
  assign bus.reg_10_colour = colour[10];
  assign bus.reg_11_colour = colour[11];
endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench: a phase-table model predicts every cycle's outputs and a
// negedge monitor compares them; directed scenarios plus random button/hold traffic.
module tb_traffic_light_sequencer;
  localparam int TICK_DIV = 4;

  typedef struct packed {
    logic [3:0]        st;
    logic              pend;
    logic [11:0][11:0] col;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  traffic_light_sequencer_if tif();
  traffic_light_sequencer #(.TICK_DIV(TICK_DIV)) dut (.clk(clk), .reset(reset), .bus(tif));

  // Phase table: duration in ticks and the three lamps lit in each phase
  int          DUR[9]     = '{10, 5, 3, 1, 10, 5, 3, 1, 8};
  int          LIT[9][3]  = '{'{2,6,4}, '{3,6,4}, '{1,6,4}, '{0,6,4}, '{8,0,4},
                              '{5,0,4}, '{7,0,4}, '{0,6,4}, '{0,6,9}};
  logic [11:0] LIT_COL[10] = '{12'hF00, 12'hFF0, 12'h0F0, 12'h0F0, 12'hF00,
                               12'h0F0, 12'hF00, 12'hFF0, 12'h0F0, 12'h0F0};
  int          KSEQ[8]    = '{1, 2, 3, 4, 5, 6, 7, 0};

  function automatic logic [11:0][11:0] lamps_for(int ph, int rem);
    logic [11:0][11:0] c;
    for (int i = 0; i < 12; i++) c[i] = 12'h333;
    for (int j = 0; j < 3; j++) begin
      int l;
      l = LIT[ph][j];
      if (l != 9 || rem > 3 || (rem % 2) == 1) c[l] = LIT_COL[l];
    end
    return c;
  endfunction

  function automatic logic [11:0][11:0] dut_colours();
    logic [11:0][11:0] c;
    c[0] = tif.reg_0_colour;   c[1] = tif.reg_1_colour;   c[2] = tif.reg_2_colour;
    c[3] = tif.reg_3_colour;   c[4] = tif.reg_4_colour;   c[5] = tif.reg_5_colour;
    c[6] = tif.reg_6_colour;   c[7] = tif.reg_7_colour;   c[8] = tif.reg_8_colour;
    c[9] = tif.reg_9_colour;   c[10] = tif.reg_10_colour; c[11] = tif.reg_11_colour;
    return c;
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: phase index, ticks remaining, cycles into the current tick
  int m_ph, m_rem, m_pcnt;
  bit m_pend;
  bit smp[3];

  always @(posedge clk) begin
    exp_t e;
    bit   tick, edge_seen, enter_walk;
    int   old_ph, nph;
    if (!reset) begin
      m_ph = 0; m_rem = DUR[0]; m_pcnt = 0; m_pend = 0;
      smp = '{default: 1'b0};
      sbq.delete();
    end else begin
      e.col = lamps_for(m_ph, m_rem);
      tick = !tif.hold && (m_pcnt == TICK_DIV - 1);
      edge_seen = smp[1] && !smp[2];
      smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = tif.ped_button;
      if (!tif.hold) m_pcnt = (m_pcnt + 1) % TICK_DIV;
      old_ph = m_ph;
      enter_walk = 0;
      if (tick) begin
        if (m_rem == 1) begin
          nph = (m_ph == 7) ? (m_pend ? 8 : 0) : ((m_ph == 8) ? 0 : m_ph + 1);
          enter_walk = (nph == 8);
          m_ph = nph;
          m_rem = DUR[nph];
        end else begin
          m_rem--;
        end
      end
      if (enter_walk) m_pend = 0;
      else if (edge_seen && old_ph != 8) m_pend = 1;
      e.st = 4'(m_ph);
      e.pend = m_pend;
      sbq.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [11:0][11:0] c;
    if (reset) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        c = dut_colours();
        chk("state_out", tif.state_out, e.st);
        chk("ped_pending", tif.ped_pending, e.pend);
        for (int i = 0; i < 12; i++) chk($sformatf("reg_%0d_colour", i), c[i], e.col[i]);
      end
    end
  end

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n;
    n = 0;
    while (tif.state_out !== s && n < budget) begin @(negedge clk); n++; end
    chk($sformatf("wait_state_%0d", s), tif.state_out, s);
  endtask

  task automatic wait_leave(input logic [3:0] s, input int budget, output int n);
    n = 0;
    while (tif.state_out === s && n < budget) begin @(negedge clk); n++; end
  endtask

  initial begin
    int cnt;
    tif.ped_button = 1'b0;
    tif.hold = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("reset_state", tif.state_out, 4'd0);
    chk("reset_pending", tif.ped_pending, 1'b0);
    chk("reset_colours", dut_colours(), lamps_for(0, 10));
    @(negedge clk); #2 reset = 1'b1;

    // Full cycle without requests: each phase lasts TICK_DIV*T cycles
    wait_state(4'd1, 100);
    for (int k = 0; k < 8; k++) begin
      wait_leave(4'(KSEQ[k]), 400, cnt);
      chk($sformatf("dur_state_%0d", KSEQ[k]), cnt, TICK_DIV * DUR[KSEQ[k]]);
    end

    // Request during R2_STRAIGHT inserts one walk phase
    wait_state(4'd4, 300);
    #2 tif.ped_button = 1'b1;
    repeat (3) @(negedge clk);
    chk("pending_latched", tif.ped_pending, 1'b1);
    #2 tif.ped_button = 1'b0;
    wait_state(4'd8, 400);
    wait_leave(4'd8, 400, cnt);
    chk("walk_duration", cnt, TICK_DIV * 8);
    chk("after_walk_state", tif.state_out, 4'd0);
    chk("after_walk_pending", tif.ped_pending, 1'b0);

    // Press during the walk is ignored
    wait_state(4'd4, 300);
    #2 tif.ped_button = 1'b1;
    repeat (2) @(negedge clk);
    #2 tif.ped_button = 1'b0;
    wait_state(4'd8, 400);
    repeat (5) @(negedge clk);
    #2 tif.ped_button = 1'b1;
    repeat (2) @(negedge clk);
    #2 tif.ped_button = 1'b0;
    repeat (4) @(negedge clk);
    chk("walk_press_ignored", tif.ped_pending, 1'b0);
    wait_state(4'd7, 400);
    wait_leave(4'd7, 100, cnt);
    chk("no_second_walk", tif.state_out, 4'd0);

    // Hold for 100 cycles mid R1_RIGHT stretches the phase by exactly 100
    wait_state(4'd1, 200);
    cnt = 0;
    repeat (7) begin @(negedge clk); cnt++; end
    #2 tif.hold = 1'b1;
    repeat (100) begin @(negedge clk); cnt++; end
    chk("hold_state", tif.state_out, 4'd1);
    #2 tif.hold = 1'b0;
    while (tif.state_out === 4'd1 && cnt < 400) begin @(negedge clk); cnt++; end
    chk("hold_total", cnt, TICK_DIV * 5 + 100);

    // Asynchronous reset mid R2_YELLOW
    wait_state(4'd6, 300);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_state", tif.state_out, 4'd0);
    chk("async_pending", tif.ped_pending, 1'b0);
    chk("async_colours", dut_colours(), lamps_for(0, 10));
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // Button toggling every cycle yields a single request and a single walk
    repeat (20) begin @(negedge clk); #2 tif.ped_button = ~tif.ped_button; end
    repeat (3) @(negedge clk);
    chk("toggle_pending", tif.ped_pending, 1'b1);
    wait_state(4'd8, 400);
    wait_state(4'd7, 400);
    wait_leave(4'd7, 100, cnt);
    chk("toggle_single_walk", tif.state_out, 4'd0);

    // Random button and hold traffic
    repeat (2500) begin
      @(negedge clk);
      #2;
      if ($urandom_range(0, 49) == 0) tif.ped_button = ~tif.ped_button;
      if ($urandom_range(0, 39) == 0) tif.hold = ~tif.hold;
    end
    @(negedge clk); #2 tif.hold = 1'b0; tif.ped_button = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
